// File: rtl/id_stage_pipelined_if.sv
// IF/ID, write-back and ID/EX signal bundle for the decode stage.
// The slave modport is the decode stage, the master side drives instructions and accepts ID/EX.
interface id_stage_pipelined_if #(parameter int XLEN = 64);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_ready;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_val;
  logic [XLEN-1:0] ex_rs2_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [1:0]      ex_alu_op;
  logic            ex_branch;
  logic            ex_mem_read;
  logic            ex_mem_to_reg;
  logic            ex_mem_write;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic            ex_illegal;
  logic            hazard_stall;

  modport master (
    output if_valid, if_pc, if_instr, flush, wb_en, wb_rd, wb_data, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_opcode, ex_funct3, ex_funct7, ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_illegal, hazard_stall
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, wb_en, wb_rd, wb_data, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_opcode, ex_funct3, ex_funct7, ex_alu_op, ex_branch, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_illegal, hazard_stall
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// RISC-V decode stage: register file with write-through, decode, load-use stall, ID/EX register.
// One-cycle latency; ID/EX holds while EX is not ready, and IF/ID is held off via id_ready.
module id_stage_pipelined #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input logic clk,
  input logic rst_n,
  id_stage_pipelined_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [1:0]      alu_op;
    ctrl_t           ctrl;
    logic            illegal;
  } ex_t;

  logic [XLEN-1:0]   regs [NREGS];
  logic [31:0]       instr;
  logic [4:0]        rs1, rs2;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic signed [31:0] imm32;
  ctrl_t             ctrl;
  logic [1:0]        alu_op;
  logic              illegal, use_rs1, use_rs2;
  logic              slot_free, hazard;
  ex_t               dec, ex_q;
  logic              ex_valid_q;

  assign instr = bus.if_instr;
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Same-cycle write-back is forwarded so decode never reads a stale operand.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0) rs1_val = (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1];
    if (rs2 != 5'd0) rs2_val = (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2];
  end

  always_comb begin
    ctrl    = '0;
    alu_op  = 2'b00;
    illegal = 1'b0;
    imm32   = '0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (instr[6:0])
      OP_R: begin
        ctrl.reg_write = 1'b1;
        alu_op  = 2'b10;
        use_rs2 = 1'b1;
      end
      OP_IALU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        alu_op = 2'b10;
        imm32  = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        alu_op  = 2'b01;
        use_rs2 = 1'b1;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1 = 1'b0;
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        ctrl.branch    = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1 = 1'b0;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl.branch    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      default: begin
        illegal = 1'b1;
        use_rs1 = 1'b0;
      end
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.if_pc;
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    dec.imm     = XLEN'(imm32);
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.rd      = instr[11:7];
    dec.opcode  = instr[6:0];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.alu_op  = alu_op;
    dec.ctrl    = ctrl;
    dec.illegal = illegal;
  end

  assign slot_free = !ex_valid_q || bus.ex_ready;
  assign hazard = bus.if_valid && ex_valid_q && ex_q.ctrl.mem_read && (ex_q.rd != 5'd0) &&
                  ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (bus.flush || (slot_free && (hazard || !bus.if_valid))) begin
      // Bubble: payload may linger, but nothing downstream may act on it.
      ex_valid_q     <= 1'b0;
      ex_q.ctrl      <= '0;
      ex_q.alu_op    <= '0;
      ex_q.illegal   <= 1'b0;
    end else if (slot_free) begin
      ex_valid_q <= 1'b1;
      ex_q       <= dec;
    end
  end

  assign bus.id_ready      = (slot_free && !hazard) || bus.flush;
  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.ex_rs1_val    = ex_q.rs1_val;
  assign bus.ex_rs2_val    = ex_q.rs2_val;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_opcode     = ex_q.opcode;
  assign bus.ex_funct3     = ex_q.funct3;
  assign bus.ex_funct7     = ex_q.funct7;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_branch     = ex_q.ctrl.branch;
  assign bus.ex_mem_read   = ex_q.ctrl.mem_read;
  assign bus.ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign bus.ex_mem_write  = ex_q.ctrl.mem_write;
  assign bus.ex_alu_src    = ex_q.ctrl.alu_src;
  assign bus.ex_reg_write  = ex_q.ctrl.reg_write;
  assign bus.ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed instructions push expected ID/EX contents,
// a monitor pops and compares each slot EX consumes.
module tb_id_stage_pipelined;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipelined_if #(.XLEN(64)) bus();
  id_stage_pipelined #(.XLEN(64), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] rs1v;
    logic [63:0] rs2v;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [1:0]  aluop;
    logic [5:0]  ctl;
    logic        ill;
  } exp_t;

  localparam logic [31:0] ADDI   = 32'hFFF28313; // addi x6,x5,-1
  localparam logic [31:0] LD     = 32'h0000B383; // ld x7,0(x1)
  localparam logic [31:0] ADD_X7 = 32'h00238433; // add x8,x7,x2
  localparam logic [31:0] ADD_X9 = 32'h00248433; // add x8,x9,x2
  localparam logic [31:0] LUI    = 32'h80000537; // lui x10,0x80000
  localparam logic [31:0] SW     = 32'hFE20AE23; // sw x2,-4(x1)
  localparam logic [31:0] BEQ    = 32'hFE000CE3; // beq x0,x0,-8
  localparam logic [31:0] ILL    = 32'h0000007F;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] rs1v,
                              input logic [63:0] rs2v, input logic [63:0] imm,
                              input logic [4:0] rd, input logic [1:0] aluop,
                              input logic [5:0] ctl, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v; e.imm = imm;
    e.rd = rd; e.aluop = aluop; e.ctl = ctl; e.ill = ill;
    return e;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
            bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ex_valid && bus.ex_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual_pc=%h required=none", bus.ex_pc);
        end else begin
          e = q.pop_front();
          chk("ex_pc", bus.ex_pc, e.pc);
          chk("ex_rs1_val", bus.ex_rs1_val, e.rs1v);
          chk("ex_rs2_val", bus.ex_rs2_val, e.rs2v);
          chk("ex_imm", bus.ex_imm, e.imm);
          chk("ex_rd", 64'(bus.ex_rd), 64'(e.rd));
          chk("ex_alu_op", 64'(bus.ex_alu_op), 64'(e.aluop));
          chk("ex_ctrl", 64'(ctl_now()), 64'(e.ctl));
          chk("ex_illegal", 64'(bus.ex_illegal), 64'(e.ill));
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [63:0] pc, input exp_t e);
    int n = 0;
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    @(negedge clk);
    while (!bus.id_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    last_wait = n;
    if (!bus.id_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pc=%h id_ready=0 required=1", pc);
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [63:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_id_ready", 64'(bus.id_ready), 64'd1);
    chk("rst_ex_imm", bus.ex_imm, 64'd0);
    chk("rst_ctrl", 64'(ctl_now()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_id_ready", 64'(bus.id_ready), 64'd1);
    @(posedge clk);
    #1;

    // x5 reads zero after reset, then the same read with a concurrent write-back
    send(ADDI, 64'h0, mk(64'h0, 64'h0, 64'h0, ONES, 5'd6, 2'b10, 6'b000011, 1'b0));
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 64'h1234;
    send(ADDI, 64'h4, mk(64'h4, 64'h1234, 64'h0, ONES, 5'd6, 2'b10, 6'b000011, 1'b0));
    bus.wb_en = 1'b0;

    write_reg(5'd1, 64'h11);
    write_reg(5'd2, 64'h22);
    write_reg(5'd7, 64'h77);
    write_reg(5'd9, 64'h99);

    // load-use: one bubble then the dependent add issues
    send(LD, 64'h8, mk(64'h8, 64'h11, 64'h0, 64'h0, 5'd7, 2'b00, 6'b011011, 1'b0));
    bus.if_valid = 1'b1; bus.if_pc = 64'hC; bus.if_instr = ADD_X7;
    @(negedge clk);
    chk("lu_hazard_stall", 64'(bus.hazard_stall), 64'd1);
    chk("lu_id_ready", 64'(bus.id_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bubble_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("bubble_ctrl", 64'(ctl_now()), 64'd0);
    chk("bubble_id_ready", 64'(bus.id_ready), 64'd1);
    q.push_back(mk(64'hC, 64'h77, 64'h22, 64'h0, 5'd8, 2'b10, 6'b000001, 1'b0));
    @(posedge clk);
    #1 bus.if_valid = 1'b0;

    // independent add after load: no stall
    send(LD, 64'h10, mk(64'h10, 64'h11, 64'h0, 64'h0, 5'd7, 2'b00, 6'b011011, 1'b0));
    bus.if_valid = 1'b1; bus.if_pc = 64'h14; bus.if_instr = ADD_X9;
    @(negedge clk);
    chk("nolu_hazard_stall", 64'(bus.hazard_stall), 64'd0);
    chk("nolu_id_ready", 64'(bus.id_ready), 64'd1);
    q.push_back(mk(64'h14, 64'h99, 64'h22, 64'h0, 5'd8, 2'b10, 6'b000001, 1'b0));
    @(posedge clk);
    #1 bus.if_valid = 1'b0;

    // back-pressure for three cycles
    send(ADDI, 64'h18, mk(64'h18, 64'h1234, 64'h0, ONES, 5'd6, 2'b10, 6'b000011, 1'b0));
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1; bus.if_pc = 64'h1C; bus.if_instr = LUI;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ex_valid", 64'(bus.ex_valid), 64'd1);
      chk("bp_ex_pc", bus.ex_pc, 64'h18);
      chk("bp_ex_rs1_val", bus.ex_rs1_val, 64'h1234);
      chk("bp_ex_imm", bus.ex_imm, ONES);
      chk("bp_id_ready", 64'(bus.id_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.ex_ready = 1'b1;
    send(LUI, 64'h1C, mk(64'h1C, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 5'd10, 2'b00, 6'b000011, 1'b0));
    chk("resume_wait_lui", 64'(last_wait), 64'd0);
    send(SW, 64'h20, mk(64'h20, 64'h11, 64'h22, 64'hFFFF_FFFF_FFFF_FFFC, 5'd28, 2'b00, 6'b000110, 1'b0));
    chk("resume_wait_sw", 64'(last_wait), 64'd0);

    // flush coinciding with a load-use hazard
    send(LD, 64'h24, mk(64'h24, 64'h11, 64'h0, 64'h0, 5'd7, 2'b00, 6'b011011, 1'b0));
    bus.if_valid = 1'b1; bus.if_pc = 64'h28; bus.if_instr = ADD_X7; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_hazard_stall", 64'(bus.hazard_stall), 64'd1);
    chk("flush_id_ready", 64'(bus.id_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", 64'(bus.ex_valid), 64'd0);
    @(posedge clk);
    #1;

    send(BEQ, 64'h30, mk(64'h30, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd25, 2'b01, 6'b100000, 1'b0));
    send(ILL, 64'h34, mk(64'h34, 64'h0, 64'h0, 64'h0, 5'd0, 2'b00, 6'b000000, 1'b1));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
# id_stage_pipelined

Parametrised decode stage that sits between the IF/ID and EX stages of the RISC-V pipeline. It owns the integer register file, decodes opcode, immediate and control, and registers the result into a valid/ready ID/EX pipeline register. Unlike a purely combinational decode, it provides the following:
- XLEN-generic datapath.
- Write-through read bypass.
- Load-use hazard stall with bubble insertion.
- Downstream back-pressure.
- Flush.

## Interface
Parameters:
- XLEN, 64, datapath width (32 or 64).
- NREGS, 32, register count; x0 reads zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID holds an instruction.
- if_pc  in  XLEN  PC of that instruction.
- if_instr  in  32  instruction word.
- id_ready  out  1  decode accepts IF/ID this cycle.
- flush  in  1  kill the instruction in ID and the ID/EX slot.
- wb_en  in  1  register write enable.
- wb_rd  in  5  write address.
- wb_data  in  XLEN  write data.
- ex_ready  in  1  EX accepts the ID/EX slot.
- ex_valid  out  1  ID/EX slot holds a live instruction.
- ex_pc  out  XLEN
- ex_rs1_val, ex_rs2_val  out  XLEN
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5
- ex_opcode  out  7
- ex_funct3  out  3
- ex_funct7  out  7
- ex_alu_op  out  2  00 load/store/LUI/AUIPC/JAL/JALR, 01 branch, 10 R/I-ALU.
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each.
- ex_illegal  out  1  unrecognised opcode.
- hazard_stall  out  1  combinational load-use stall indicator.

## Operation
Register file:
- NREGS x XLEN, written on the clk edge when wb_en and wb_rd != 0.
- Reads of x0 return 0.
- Write-through: if wb_en and wb_rd == rs and rs != 0, the read returns wb_data in the same cycle.
- Contents reset to 0.

Immediate generation. All immediates sign-extend bit 31 to XLEN.
- I-type: [31:20].
- S-type: {[31:25],[11:7]}.
- B-type: {[31],[7],[30:25],[11:8],0}.
- U-type: {[31:12],12'b0}.
- J-type: {[31],[19:12],[20],[30:21],0}.
- R-type and illegal opcodes: 0.

Control by opcode:
- R 0110011: reg_write.
- I-ALU 0010011: alu_src, reg_write.
- Load 0000011: alu_src, mem_read, mem_to_reg, reg_write.
- Store 0100011: alu_src, mem_write.
- Branch 1100011: branch.
- LUI 0110111, AUIPC 0010111: alu_src, reg_write.
- JAL 1101111, JALR 1100111: branch, reg_write; JALR also sets alu_src.
- Any other opcode: all controls 0, ex_illegal = 1.

Rs usage:
- rs1 is used by every format except LUI, AUIPC and JAL.
- rs2 is used only by R, store and branch.

Load-use hazard:
- hazard_stall = if_valid & ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd matches a used rs of if_instr).
- ID/EX is loaded when slot_free = !ex_valid | ex_ready.
- id_ready = slot_free & !hazard_stall, or flush.

Register update on the clk edge, in priority order:
1. flush: ex_valid <= 0. The IF/ID instruction is consumed and dropped.
2. slot_free & hazard_stall: ex_valid <= 0 (bubble). IF/ID is held, and the load advances.
3. slot_free & if_valid: all ex_* are loaded from the decode, and ex_valid <= 1.
4. slot_free & !if_valid: ex_valid <= 0.
5. Otherwise (ex_valid & !ex_ready): all ex_* hold.

Payload fields are don't-care while ex_valid = 0, but a bubble must clear all control outputs to 0.

## Timing
- Reset (asynchronous assert, synchronous release): ex_valid = 0, all ex_* = 0, register file = 0. id_ready reflects its combinational equation right after reset, i.e. 1.
- Latency: an instruction presented with if_valid & id_ready appears on ex_* at the next rising edge. Throughput is 1 per cycle.
- Load-use: the dependent instruction incurs exactly one bubble cycle, then issues. Its operands are read in the cycle it is accepted.
- A WB write and a read of the same register in one cycle: the read sees the new data.
- Simultaneous flush and hazard: flush wins, and no stall is signalled to IF (id_ready = 1).
- Back-pressure: while ex_valid & !ex_ready, ex_* are stable and id_ready = 0.
- Reset asserted mid-operation clears the slot immediately. The in-flight instruction is lost.

## Test plan
- Reset: hold rst_n = 0, then release. Required: ex_valid = 0, id_ready = 1, and reading x5 returns 0.
- Write-through: wb_en = 1, wb_rd = 5, wb_data = 0x1234 in the same cycle as addi x6,x5,-1 (0xFFF28313). Required: next cycle ex_rs1_val = 0x1234, ex_imm = 0xFFFF_FFFF_FFFF_FFFF, ex_reg_write = 1, ex_alu_src = 1.
- Load-use: ld x7,0(x1), then add x8,x7,x2. Required:
  - With ld in EX and add in ID: hazard_stall = 1, id_ready = 0.
  - One bubble follows (ex_valid = 0, controls 0), then add issues.
  - The same ld followed by add x8,x9,x2 produces no stall.
- Back-pressure: hold ex_ready = 0 for 3 cycles with a valid slot. Required: ex_* unchanged and id_ready = 0. Releasing ex_ready resumes one instruction per cycle.
- Flush: assert flush together with a hazard and if_valid = 1. Required: id_ready = 1 and ex_valid = 0 next cycle.
- Immediates and illegal: beq with offset -8, and an illegal opcode 0x7F. Required: beq gives ex_imm = -8, ex_branch = 1, ex_alu_op = 01. The illegal opcode gives ex_illegal = 1 and all controls 0.
